countdown_seq_ctrl: RTL

- Sequencer for an MM:SS countdown built from two DigitTimer instances: one for seconds, one for minutes.
- Generates the one-second decrement pulses and loads preset BCD digits.
- Handles the seconds-to-minutes borrow by reloading seconds to 59.
- Handles start/pause/clear control and raises Done when 00:00 is reached.

---
 rtl/countdown_seq_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/countdown_seq_ctrl.sv
// countdown_seq_ctrl
// ------------------
// Sequencer for an MM:SS countdown built from two external DigitTimer
// instances (seconds and minutes). It generates the one-second decrement
// pulses, loads sanitised BCD presets, reloads seconds to 59 when a
// seconds-to-minutes borrow is needed, handles start/pause/clear, and raises
// Done when 00:00 is reached.
//
// Optional feature (macro AUTO_RELOAD_EN):
//   defined   - DONE lasts exactly CLK_PER_SEC cycles, then the sequencer
//               reloads the presets and counts down again.
//   undefined - DONE holds until StartBtn or ClearBtn; prescaler frozen.
//
// Ports:
//   clk, rst                        clock (rising edge), async active-low reset
//   StartBtn, PauseBtn, ClearBtn    single-cycle control pulses
//   MinTensSet, MinUnitsSet,
//   SecTensSet, SecUnitsSet         BCD preset digits
//   SecFin, MinFin                  "count is 00" flags from the DigitTimers
//   SecTensLoadVal/SecUnitsLoadVal,
//   SecTensLoad/SecUnitsLoad/SecDec load data, load strobes, decrement (seconds)
//   MinTensLoadVal/MinUnitsLoadVal,
//   MinTensLoad/MinUnitsLoad/MinDec load data, load strobes, decrement (minutes)
//   Running                         high in RUN or BORROW
//   Done                            high while the countdown sits at 00:00
//
// All outputs are registered: each is computed from the next state and
// appears in the cycle after the decision is made.

module countdown_seq_ctrl #(
  parameter int CLK_PER_SEC = 50000000,
  parameter int CNT_W       = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       StartBtn,
  input  logic       PauseBtn,
  input  logic       ClearBtn,
  input  logic [3:0] MinTensSet,
  input  logic [3:0] MinUnitsSet,
  input  logic [3:0] SecTensSet,
  input  logic [3:0] SecUnitsSet,
  input  logic       SecFin,
  input  logic       MinFin,
  output logic [3:0] SecTensLoadVal,
  output logic [3:0] SecUnitsLoadVal,
  output logic       SecTensLoad,
  output logic       SecUnitsLoad,
  output logic       SecDec,
  output logic [3:0] MinTensLoadVal,
  output logic [3:0] MinUnitsLoadVal,
  output logic       MinTensLoad,
  output logic       MinUnitsLoad,
  output logic       MinDec,
  output logic       Running,
  output logic       Done
);

  localparam logic [CNT_W-1:0] PRE_MAX = CNT_W'(CLK_PER_SEC - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_BORROW,
    ST_PAUSE,
    ST_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] pre, pre_nxt, pre_inc;
  logic             pause_pend, pend_nxt;
  logic             tick;
  logic             sec_dec_nxt, min_dec_nxt, borrow_ld;
  logic             loading;
  logic [3:0]       sec_tens_val_nxt, sec_units_val_nxt;
  logic [3:0]       min_tens_val_nxt, min_units_val_nxt;

  // Clamp a BCD digit to an upper limit (out-of-range presets load as the limit).
  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  assign pre_inc = (pre == PRE_MAX) ? '0 : pre + CNT_W'(1);
  assign tick    = (state == ST_RUN) && (pre == PRE_MAX);

  // Next-state and next-output decode. A pause that coincides with a
  // borrowing tick is remembered in pause_pend so that BORROW still
  // completes its seconds reload before the sequencer parks in PAUSE.
  always_comb begin
    state_nxt   = state;
    pre_nxt     = pre;
    pend_nxt    = pause_pend;
    sec_dec_nxt = 1'b0;
    min_dec_nxt = 1'b0;
    borrow_ld   = 1'b0;

    case (state)
      ST_IDLE: begin
        pre_nxt = '0;
        if (StartBtn) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        pre_nxt   = pre_inc;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        pre_nxt = pre_inc;
        if (tick) begin
          if (SecFin && MinFin) begin
            state_nxt = ST_DONE;
          end else if (SecFin) begin
            min_dec_nxt = 1'b1;
            pend_nxt    = PauseBtn;
            state_nxt   = ST_BORROW;
          end else begin
            sec_dec_nxt = 1'b1;
            state_nxt   = PauseBtn ? ST_PAUSE : ST_RUN;
          end
        end else if (PauseBtn) begin
          state_nxt = ST_PAUSE;
        end
      end
      ST_BORROW: begin
        pre_nxt   = pre_inc;
        borrow_ld = 1'b1;
        pend_nxt  = 1'b0;
        state_nxt = pause_pend ? ST_PAUSE : ST_RUN;
      end
      ST_PAUSE: begin
        if (StartBtn || PauseBtn) state_nxt = ST_RUN;
      end
      ST_DONE: begin
`ifdef AUTO_RELOAD_EN
        // The prescaler times the Done window; its wrap triggers the reload.
        pre_nxt = pre_inc;
        if (pre == PRE_MAX) state_nxt = ST_LOAD;
`else
        pre_nxt = pre;
`endif
        if (StartBtn) state_nxt = ST_LOAD;
      end
      default: begin
        state_nxt = ST_IDLE;
        pre_nxt   = '0;
        pend_nxt  = 1'b0;
      end
    endcase

    if (state_nxt == ST_LOAD) pre_nxt = '0;

    // Clear overrides every other event, including strobes decided above.
    if (ClearBtn) begin
      state_nxt   = ST_IDLE;
      pre_nxt     = '0;
      pend_nxt    = 1'b0;
      sec_dec_nxt = 1'b0;
      min_dec_nxt = 1'b0;
      borrow_ld   = 1'b0;
    end

    loading           = (state_nxt == ST_LOAD);
    sec_tens_val_nxt  = 4'd0;
    sec_units_val_nxt = 4'd0;
    min_tens_val_nxt  = 4'd0;
    min_units_val_nxt = 4'd0;
    if (loading) begin
      sec_tens_val_nxt  = clamp_digit(SecTensSet, 4'd5);
      sec_units_val_nxt = clamp_digit(SecUnitsSet, 4'd9);
      min_tens_val_nxt  = clamp_digit(MinTensSet, 4'd9);
      min_units_val_nxt = clamp_digit(MinUnitsSet, 4'd9);
    end else if (borrow_ld) begin
      sec_tens_val_nxt  = 4'd5;
      sec_units_val_nxt = 4'd9;
    end
  end

  // State, prescaler and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= ST_IDLE;
      pre             <= '0;
      pause_pend      <= 1'b0;
      SecTensLoadVal  <= 4'd0;
      SecUnitsLoadVal <= 4'd0;
      SecTensLoad     <= 1'b0;
      SecUnitsLoad    <= 1'b0;
      SecDec          <= 1'b0;
      MinTensLoadVal  <= 4'd0;
      MinUnitsLoadVal <= 4'd0;
      MinTensLoad     <= 1'b0;
      MinUnitsLoad    <= 1'b0;
      MinDec          <= 1'b0;
      Running         <= 1'b0;
      Done            <= 1'b0;
    end else begin
      state           <= state_nxt;
      pre             <= pre_nxt;
      pause_pend      <= pend_nxt;
      SecTensLoadVal  <= sec_tens_val_nxt;
      SecUnitsLoadVal <= sec_units_val_nxt;
      SecTensLoad     <= loading || borrow_ld;
      SecUnitsLoad    <= loading || borrow_ld;
      SecDec          <= sec_dec_nxt;
      MinTensLoadVal  <= min_tens_val_nxt;
      MinUnitsLoadVal <= min_units_val_nxt;
      MinTensLoad     <= loading;
      MinUnitsLoad    <= loading;
      MinDec          <= min_dec_nxt;
      Running         <= (state_nxt == ST_RUN) || (state_nxt == ST_BORROW);
      Done            <= (state_nxt == ST_DONE);
    end
  end

endmodule
